// File: rtl/karatsuba_mul_arbiter.sv
// Two-port round-robin front end for the shared iterative Karatsuba multiplier core.
// Each job runs clear -> LATENCY enable cycles -> tagged response held until taken.
module karatsuba_mul_arbiter #(
  parameter int N       = 32,
  parameter int LATENCY = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [2*N-1:0] resp_data,
  output logic           mul_rst,
  output logic           mul_en,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_c,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t     state;
  logic       last_grant;
  logic [7:0] cnt;
  logic       grant0;
  logic       grant1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      mul_rst    <= 1'b0;
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            mul_a      <= grant0 ? req0_a : req1_a;
            mul_b      <= grant0 ? req0_b : req1_b;
            resp_id    <= grant1;
            last_grant <= grant1;
            mul_rst    <= 1'b1;
            busy       <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          mul_rst <= 1'b0;
          mul_en  <= 1'b1;
          cnt     <= CNT_LOAD;
          state   <= RUN;
        end
        // The last enable cycle is the one where the core product becomes valid.
        RUN: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            resp_data  <= mul_c;
            resp_valid <= 1'b1;
            mul_en     <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Self-checking bench for karatsuba_mul_arbiter with a behavioural multiplier core
// and a job-level reference model for grants, latency and products.
module tb_karatsuba_mul_arbiter;

  localparam int N       = 32;
  localparam int LATENCY = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready;
  logic [N-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [N-1:0]   req1_a, req1_b;
  logic           resp_valid, resp_ready, resp_id;
  logic [2*N-1:0] resp_data;
  logic           mul_rst, mul_en;
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] mul_c;
  logic           busy;

  int vectors    = 0;
  int miscompares = 0;
  logic rr_ids[$];

  always #5 clk = ~clk;

  karatsuba_mul_arbiter #(.N(N), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .busy(busy)
  );

  // Core model: product is visible only during the LATENCY-th enable cycle after a clear.
  int core_cnt = 0;
  always @(posedge clk) begin
    if (mul_rst)     core_cnt <= 0;
    else if (mul_en) core_cnt <= core_cnt + 1;
  end
  assign mul_c = (core_cnt == LATENCY - 1) ? ({32'b0, mul_a} * {32'b0, mul_b})
                                           : {32'hBAD0BAD0, 32'(core_cnt)};

  function automatic logic [63:0] b64(input logic x);
    return {63'b0, x};
  endfunction

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0);
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!resp_valid && n < 3 * LATENCY + 10) begin
      tick(); #1; n++;
    end
    checkOutput({tag, " resp_valid"}, b64(resp_valid), 64'd1);
  endtask

  // One job from an idle arbiter, checking every cycle of the clear/run/response sequence.
  task automatic directed_job(input bit id, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] expected);
    drive_req(id, 1'b1, a, b);
    resp_ready = 1'b0;
    #1;
    checkOutput("dj granted ready", b64(id ? req1_ready : req0_ready), 64'd1);
    checkOutput("dj other ready", b64(id ? req0_ready : req1_ready), 64'd0);
    tick();
    drive_req(id, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    #1;
    checkOutput("dj clear mul_rst", b64(mul_rst), 64'd1);
    checkOutput("dj clear mul_en", b64(mul_en), 64'd0);
    checkOutput("dj mul_a", 64'(mul_a), 64'(a));
    checkOutput("dj mul_b", 64'(mul_b), 64'(b));
    checkOutput("dj busy", b64(busy), 64'd1);
    for (int k = 1; k <= LATENCY + 1; k++) begin
      tick(); #1;
      checkOutput("dj run mul_rst", b64(mul_rst), 64'd0);
      checkOutput("dj run mul_en", b64(mul_en), b64(k <= LATENCY));
      checkOutput("dj resp_valid timing", b64(resp_valid), b64(k == LATENCY + 1));
    end
    checkOutput("dj resp_data", resp_data, expected);
    checkOutput("dj resp_id", b64(resp_id), b64(id));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    checkOutput("dj resp_valid cleared", b64(resp_valid), 64'd0);
    checkOutput("dj busy cleared", b64(busy), 64'd0);
  endtask

  task automatic back_pressure();
    logic [31:0] a0, b0, a1, b1;
    logic [63:0] exp0;
    a0 = $urandom | 32'h1; b0 = $urandom | 32'h1;
    a1 = $urandom | 32'h1; b1 = $urandom | 32'h1;
    exp0 = prod(a0, b0);
    drive_req(1'b0, 1'b1, a0, b0);
    resp_ready = 1'b0;
    #1;
    checkOutput("bp req0_ready", b64(req0_ready), 64'd1);
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b1, a1, b1);
    #1;
    wait_resp("bp first");
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp resp_data stable", resp_data, exp0);
      checkOutput("bp resp_valid held", b64(resp_valid), 64'd1);
      checkOutput("bp req1_ready low", b64(req1_ready), 64'd0);
      checkOutput("bp busy", b64(busy), 64'd1);
      tick(); #1;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    checkOutput("bp req1_ready after release", b64(req1_ready), 64'd1);
    checkOutput("bp resp_valid cleared", b64(resp_valid), 64'd0);
    tick();
    drive_req(1'b1, 1'b0, '0, '0);
    #1;
    wait_resp("bp second");
    checkOutput("bp second resp_data", resp_data, prod(a1, b1));
    checkOutput("bp second resp_id", b64(resp_id), 64'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    drive_req(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF1);
    resp_ready = 1'b1;
    tick();
    drive_req(1'b1, 1'b0, '0, '0);
    repeat (5) tick();
    #1;
    checkOutput("mr in run", b64(mul_en), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr mul_rst", b64(mul_rst), 64'd0);
    checkOutput("mr mul_en", b64(mul_en), 64'd0);
    checkOutput("mr mul_a", 64'(mul_a), 64'd0);
    checkOutput("mr mul_b", 64'(mul_b), 64'd0);
    checkOutput("mr resp_valid", b64(resp_valid), 64'd0);
    checkOutput("mr resp_id", b64(resp_id), 64'd0);
    checkOutput("mr resp_data", resp_data, 64'd0);
    checkOutput("mr busy", b64(busy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < LATENCY + 5; i++) begin
      tick(); #1;
      checkOutput("mr no response", b64(resp_valid), 64'd0);
      checkOutput("mr idle", b64(busy), 64'd0);
    end
    resp_ready = 1'b0;
  endtask

  // Job-level model: free/waiting/responding, round-robin from the last grant.
  task automatic applyStimulus(input int n_jobs, input int pv, input int pr);
    int          issued = 0;
    int          responded = 0;
    int          cycles = 0;
    int          wait_cnt = 0;
    bit          model_free = 1'b1;
    bit          model_last = 1'b1;
    bit          pending [2] = '{1'b0, 1'b0};
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    int          issued_id [2] = '{0, 0};
    int          dut_returned [2] = '{0, 0};
    bit          cur_id = 1'b0;
    logic [63:0] cur_prod = '0;
    bit          exp_g0, exp_g1, took;
    rr_ids.delete();
    while (responded < n_jobs && cycles < n_jobs * 40 + 200) begin
      for (int i = 0; i < 2; i++) begin
        if (!pending[i] && issued < n_jobs && $urandom_range(99) < pv) begin
          pending[i] = 1'b1;
          pa[i] = rand_operand();
          pb[i] = rand_operand();
          issued++;
          drive_req(1'(i), 1'b1, pa[i], pb[i]);
        end
      end
      resp_ready = ($urandom_range(99) < pr);
      #1;
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (model_free) begin
        if (pending[0] && pending[1]) begin
          exp_g0 = model_last;
          exp_g1 = !model_last;
        end else begin
          exp_g0 = pending[0];
          exp_g1 = pending[1];
        end
      end
      checkOutput("rand req0_ready", b64(req0_ready), b64(exp_g0));
      checkOutput("rand req1_ready", b64(req1_ready), b64(exp_g1));
      checkOutput("rand busy", b64(busy), b64(!model_free));
      checkOutput("rand resp_valid", b64(resp_valid), b64(!model_free && wait_cnt == 0));
      if (resp_valid && resp_ready) begin
        dut_returned[resp_id]++;
        rr_ids.push_back(resp_id);
      end
      took = 1'b0;
      if (!model_free && wait_cnt == 0 && resp_ready) begin
        checkOutput("rand resp_id", b64(resp_id), b64(cur_id));
        checkOutput("rand resp_data", resp_data, cur_prod);
        responded++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (took) model_free = 1'b1;
      else if (!model_free && wait_cnt > 0) wait_cnt--;
      if (exp_g0 || exp_g1) begin
        model_last = exp_g1;
        pending[exp_g1] = 1'b0;
        drive_req(exp_g1, 1'b0, '0, '0);
        model_free = 1'b0;
        wait_cnt = LATENCY + 1;
        cur_id = exp_g1;
        cur_prod = prod(pa[exp_g1], pb[exp_g1]);
        issued_id[exp_g1]++;
      end
    end
    drive_req(1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0);
    resp_ready = 1'b0;
    checkOutput("rand all jobs returned", 64'(responded), 64'(n_jobs));
    checkOutput("rand req0 returned once", 64'(dut_returned[0]), 64'(issued_id[0]));
    checkOutput("rand req1 returned once", 64'(dut_returned[1]), 64'(issued_id[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    drive_req(1'b0, 1'b1, 32'h1, 32'h1);
    drive_req(1'b1, 1'b1, 32'h2, 32'h2);
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset req0_ready", b64(req0_ready), 64'd0);
    checkOutput("reset req1_ready", b64(req1_ready), 64'd0);
    checkOutput("reset busy", b64(busy), 64'd0);
    checkOutput("reset mul_rst", b64(mul_rst), 64'd0);
    checkOutput("reset mul_en", b64(mul_en), 64'd0);
    checkOutput("reset mul_a", 64'(mul_a), 64'd0);
    checkOutput("reset resp_valid", b64(resp_valid), 64'd0);
    checkOutput("reset resp_data", resp_data, 64'd0);
    drive_req(1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single job and extremes");
    directed_job(1'b0, 32'd1100000, 32'd111, 64'd122100000);
    directed_job(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    directed_job(1'b0, 32'h0, 32'hFFFF_FFFF, 64'h0);
    directed_job(1'b1, 32'h1, 32'h1, 64'h1);

    $display("[TB] back-pressure");
    back_pressure();
    tick();

    $display("[TB] reset during run");
    reset_mid_run();
    directed_job(1'b0, 32'd3, 32'd5, 64'd15);

    $display("[TB] round-robin");
    do_reset();
    applyStimulus(4, 100, 100);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr resp_id order", b64(rr_ids.size() > i ? rr_ids[i] : 1'bx), b64(i % 2 == 1));
    end

    $display("[TB] random jobs");
    do_reset();
    applyStimulus(1000, 50, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
